// File: rtl/pipeline_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundles the hazard controller's pipeline-side signals.
//   master : pipeline side, drives hazard sources and observes controls
//   slave  : hazard controller, observes sources and drives controls
// Sources : id_rs1/id_rs2 (+_used), exe_is_load, exe_rd, exe_branch_taken,
//           mem_op, mem_ack
// Controls: pc_en, en_* pipeline-register enables, flush_* bubble loads,
//           mem_err (sticky watchdog flag), stall_cnt (stall performance count)
// ----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic                  exe_is_load;
    logic [REG_ADDR_W-1:0] exe_rd;
    logic                  exe_branch_taken;
    logic                  mem_op;
    logic                  mem_ack;

    logic                  pc_en;
    logic                  en_if_id;
    logic                  en_id_exe;
    logic                  en_exe_mem;
    logic                  en_mem_wb;
    logic                  flush_if_id;
    logic                  flush_id_exe;
    logic                  flush_mem_wb;
    logic                  mem_err;
    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, exe_is_load, exe_rd,
               exe_branch_taken, mem_op, mem_ack,
        input  pc_en, en_if_id, en_id_exe, en_exe_mem, en_mem_wb, flush_if_id,
               flush_id_exe, flush_mem_wb, mem_err, stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, exe_is_load, exe_rd,
               exe_branch_taken, mem_op, mem_ack,
        output pc_en, en_if_id, en_id_exe, en_exe_mem, en_mem_wb, flush_if_id,
               flush_id_exe, flush_mem_wb, mem_err, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Stall/flush sequencer for the 5-stage pipeline. Resolves multi-cycle MEM
// accesses (highest priority), taken branches, then load-use hazards. Includes
// a MEM-wait watchdog and a saturating stall-cycle counter.
// Ports:
//   clk   : pipeline clock, rising edge
//   rst   : synchronous active-high reset
//   io_hz : pipeline_hazard_ctrl_if.slave (sources in, enables/flushes out)
// REG_ADDR_W and CNT_W must match the connected interface instance.
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W  = 4,
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_hazard_ctrl_if.slave io_hz
);

    localparam int unsigned   WdW   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WdW-1:0] WdMax = WdW'(MEM_TIMEOUT);

    typedef enum logic [0:0] {StRun, StMemWait} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WdW-1:0]   r_wd;
    logic [WdW-1:0]   w_wd_next;
    logic             r_mem_err;
    logic             w_err_set;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_hazard;
    logic w_freeze;
    logic w_pc_en;
    logic w_en_if_id;
    logic w_en_id_exe;
    logic w_en_exe_mem;
    logic w_en_mem_wb;
    logic w_flush_if_id;
    logic w_flush_id_exe;
    logic w_flush_mem_wb;

    // Register 0 is compared like any other register.
    assign w_hazard = io_hz.exe_is_load &
                      ((io_hz.id_rs1_used & (io_hz.id_rs1 == io_hz.exe_rd)) |
                       (io_hz.id_rs2_used & (io_hz.id_rs2 == io_hz.exe_rd)));

    // In MEM_WAIT mem_op is not re-sampled: only the ack releases the freeze.
    assign w_freeze = (r_state == StRun) ? (io_hz.mem_op & ~io_hz.mem_ack)
                                         : ~io_hz.mem_ack;

    always_comb begin
        w_pc_en        = 1'b1;
        w_en_if_id     = 1'b1;
        w_en_id_exe    = 1'b1;
        w_en_exe_mem   = 1'b1;
        w_en_mem_wb    = 1'b1;
        w_flush_if_id  = 1'b0;
        w_flush_id_exe = 1'b0;
        w_flush_mem_wb = 1'b0;
        w_state_next   = r_state;
        w_wd_next      = r_wd;
        w_err_set      = 1'b0;

        if (rst) begin
            w_pc_en        = 1'b0;
            w_en_if_id     = 1'b0;
            w_en_id_exe    = 1'b0;
            w_en_exe_mem   = 1'b0;
            w_en_mem_wb    = 1'b0;
            w_flush_if_id  = 1'b1;
            w_flush_id_exe = 1'b1;
            w_flush_mem_wb = 1'b1;
        end else if (w_freeze) begin
            w_pc_en        = 1'b0;
            w_en_if_id     = 1'b0;
            w_en_id_exe    = 1'b0;
            w_en_exe_mem   = 1'b0;
            w_en_mem_wb    = 1'b0;
            w_flush_mem_wb = 1'b1;
            if (r_state == StRun) begin
                w_state_next = StMemWait;
                w_wd_next    = WdW'(1);
            end else if (r_wd == WdMax) begin
                // Watchdog abort: freeze holds this cycle, RUN resumes next.
                w_state_next = StRun;
                w_wd_next    = '0;
                w_err_set    = 1'b1;
            end else begin
                w_wd_next = r_wd + 1'b1;
            end
        end else begin
            // Ack cycle in MEM_WAIT behaves as RUN for branch/hazard handling.
            if (r_state == StMemWait) begin
                w_state_next = StRun;
                w_wd_next    = '0;
            end
            if (io_hz.exe_branch_taken) begin
                // ID instruction is squashed, so any load-use match is moot.
                w_flush_if_id  = 1'b1;
                w_flush_id_exe = 1'b1;
            end else if (w_hazard) begin
                w_pc_en        = 1'b0;
                w_en_if_id     = 1'b0;
                w_flush_id_exe = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StRun;
            r_wd        <= '0;
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_wd    <= w_wd_next;
            if (w_err_set) begin
                r_mem_err <= 1'b1;
            end
            if (!w_pc_en && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign io_hz.pc_en        = w_pc_en;
    assign io_hz.en_if_id     = w_en_if_id;
    assign io_hz.en_id_exe    = w_en_id_exe;
    assign io_hz.en_exe_mem   = w_en_exe_mem;
    assign io_hz.en_mem_wb    = w_en_mem_wb;
    assign io_hz.flush_if_id  = w_flush_if_id;
    assign io_hz.flush_id_exe = w_flush_id_exe;
    assign io_hz.flush_mem_wb = w_flush_mem_wb;
    assign io_hz.mem_err      = r_mem_err;
    assign io_hz.stall_cnt    = r_stall_cnt;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage filter-processor pipeline.
- Drives the EN inputs of the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers, the PC enable, and bubble (flush) controls.
- Resolves three conditions: load-use hazards, taken branches, and multi-cycle data-memory accesses in the MEM stage.
- Provides a memory watchdog and a stall-cycle performance counter.

Parameters:
- REG_ADDR_W, 4: register-address width; matches srcRegDir.
- MEM_TIMEOUT, 64: maximum cycles in MEM_WAIT before the watchdog aborts the wait.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs1  in  REG_ADDR_W  source register 1 of the instruction in ID.
- id_rs2  in  REG_ADDR_W  source register 2 of the instruction in ID.
- id_rs1_used  in  1  ID instruction reads rs1.
- id_rs2_used  in  1  ID instruction reads rs2.
- exe_is_load  in  1  instruction in EXE is a memory load.
- exe_rd  in  REG_ADDR_W  destination register of the EXE instruction.
- exe_branch_taken  in  1  branch resolved taken in EXE this cycle.
- mem_op  in  1  instruction in MEM accesses data memory.
- mem_ack  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC update enable.
- en_if_id  out  1  EN for the IF/ID register.
- en_id_exe  out  1  EN for the ID/EXE register.
- en_exe_mem  out  1  EN for the EXE/MEM register.
- en_mem_wb  out  1  EN for the MEM/WB register.
- flush_if_id  out  1  load a bubble (ctrl=0) into IF/ID.
- flush_id_exe  out  1  load a bubble into ID/EXE.
- flush_mem_wb  out  1  load a bubble into MEM/WB.
- mem_err  out  1  sticky: watchdog timeout occurred.
- stall_cnt  out  CNT_W  count of cycles with pc_en=0 outside reset.

Behaviour:

State and outputs:
- FSM states: RUN, MEM_WAIT (registered). Watchdog counter wd (registered, 0..MEM_TIMEOUT).
- All enable and flush outputs are combinational from the current state and inputs, and are valid in the same cycle.
- Default in RUN with no event: all EN=1, pc_en=1, all flush=0.

Reset:
- While rst=1: state<=RUN, wd<=0, mem_err<=0, stall_cnt<=0.
- Outputs during reset: pc_en=0, all EN=0, all flush=1.
- Reset asserted mid-MEM_WAIT aborts the wait with no mem_err.

Condition priority (highest first):
1. Memory wait.
   - In RUN with mem_op=1 and mem_ack=0: freeze the pipeline this cycle (pc_en=0, all EN=0, flush_mem_wb=1), then go to MEM_WAIT with wd<=1.
   - In RUN with mem_op=1 and mem_ack=1: no stall.
   - In MEM_WAIT with mem_ack=0: keep the freeze outputs; wd<=wd+1.
   - In MEM_WAIT with mem_ack=1: that cycle behaves as RUN (rules 2 and 3 are evaluated), then state<=RUN, wd<=0.
   - In MEM_WAIT with wd==MEM_TIMEOUT and no ack: mem_err<=1, state<=RUN. The freeze still holds for this cycle; the next cycle proceeds normally.
2. Taken branch (exe_branch_taken=1): pc_en=1, all EN=1, flush_if_id=1, flush_id_exe=1. A simultaneous load-use hazard is ignored because the ID instruction is squashed.
3. Load-use hazard.
   - Hazard = exe_is_load & ((id_rs1_used & id_rs1==exe_rd) | (id_rs2_used & id_rs2==exe_rd)).
   - Outputs: pc_en=0, en_if_id=0, en_id_exe=1, flush_id_exe=1, en_exe_mem=1, en_mem_wb=1.
   - Register 0 is not special and is compared like any other register.

Counters and flags:
- stall_cnt increments on every non-reset cycle with pc_en=0 and saturates at all-ones.
- mem_err is cleared only by rst.
- mem_op and mem_ack are sampled only as described above; mem_ack in RUN without mem_op is ignored.

Test Plan:
1. Reset: rst=1 for 2 cycles with mem_op=1 -> pc_en=0, EN=0, flush=1, stall_cnt=0. After release with no events -> all EN=1, flushes=0.
2. Load-use: exe_is_load=1, exe_rd=5, id_rs2=5, id_rs2_used=1 -> exactly one cycle of pc_en=0, en_if_id=0, flush_id_exe=1; stall_cnt=1. Repeat with id_rs2_used=0 -> no stall.
3. Branch + hazard in the same cycle: exe_branch_taken=1 with a load-use match -> pc_en=1, flush_if_id=1, flush_id_exe=1, en_if_id=1; stall_cnt unchanged.
4. Memory wait: mem_op=1 with mem_ack arriving 3 cycles later -> 3 frozen cycles (all EN=0, flush_mem_wb=1). In the ack cycle all EN=1. stall_cnt=3.
5. Watchdog: MEM_TIMEOUT=4, mem_op=1 and mem_ack never asserted -> mem_err=1 after the 4th MEM_WAIT cycle, then state RUN. mem_err stays 1 until rst.
6. Saturation: CNT_W=4 with 20 stall cycles -> stall_cnt=15.
